countdown_timer: RTL and testbench

//   Loadable mm:ss countdown timer for the alarm clock. It is the down-counting counterpart of the
//   mod-N up-counter chain: it borrows from minutes into seconds and flags terminal count at 0:00.
//   It is driven by the shared 1 Hz tick enable and feeds the display mux and the buzzer driver.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/ct_down_mod_N.sv | 40 ++++
 rtl/countdown_timer.sv | 137 +++++++++++++
 tb/tb_countdown_timer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the mm:ss countdown timer.
// Exports tmr_state_t, default moduli and a saturating clamp.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } tmr_state_t;

  localparam int SEC_N_DEF   = 60;
  localparam int MIN_MAX_DEF = 59;

  function automatic logic [6:0] clamp7(
    input logic [6:0] v,
    input logic [6:0] mx
  );
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/ct_down_mod_N.sv
// Mod-N down counter: N-1..0, wraps to N-1 on en at 0, ld wins.
// Ports: clk, rst, en, ld, ld_val[6:0] -> ct_out[6:0], z (ct_out==0).
module ct_down_mod_N
  import timer_pkg::*;
#(
  parameter int N = SEC_N_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ld,
  input  logic [6:0] ld_val,
  output logic [6:0] ct_out,
  output logic       z
);

  logic [6:0] ct_q;
  logic [6:0] ct_d;

  always_comb begin
    ct_d = ct_q;
    if (ld) begin
      ct_d = ld_val;
    end else if (en) begin
      ct_d = z ? 7'(N - 1) : ct_q - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ct_q <= '0;
    end else begin
      ct_q <= ct_d;
    end
  end

  assign ct_out = ct_q;
  assign z      = (ct_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable mm:ss countdown timer with IDLE/RUN/PAUSE/EXPIRED control.
// In: clk rst tick load ld_min ld_sec start stop; out: min_out sec_out running expired buzz. Option: AUTO_RELOAD_EN.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int SEC_N   = SEC_N_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [6:0] ld_min,
  input  logic [6:0] ld_sec,
  input  logic       start,
  input  logic       stop,
  output logic [6:0] min_out,
  output logic [6:0] sec_out,
  output logic       running,
  output logic       expired,
  output logic       buzz
);

  tmr_state_t state_q, state_d;
  logic running_q, running_d;
  logic expired_q, expired_d;
  logic buzz_q, buzz_d;

  logic [6:0] ld_min_c, ld_sec_c;
  logic [6:0] cnt_min_v, cnt_sec_v;
  logic sec_z, min_z, cnt_zero;
  logic run_tick, expiring, reload_hit, cnt_ld;
  logic startable;

  assign ld_sec_c = clamp7(ld_sec, 7'(SEC_N - 1));
  assign ld_min_c = clamp7(ld_min, 7'(MIN_MAX));
  assign cnt_zero = sec_z & min_z;

  // load and stop both outrank a tick on the same edge.
  assign run_tick = tick & ~load & ~stop & (state_q == RUN);
  // Count is at 0:01, so this tick lands on 0:00.
  assign expiring = run_tick & min_z & (sec_out == 7'd1);

`ifdef AUTO_RELOAD_EN
  logic [6:0] rl_min_q, rl_sec_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rl_min_q <= '0;
      rl_sec_q <= '0;
    end else if (load) begin
      rl_min_q <= ld_min_c;
      rl_sec_q <= ld_sec_c;
    end
  end

  assign reload_hit = expiring & ((rl_min_q | rl_sec_q) != '0);
  assign cnt_ld     = load | reload_hit;
  assign cnt_min_v  = load ? ld_min_c : rl_min_q;
  assign cnt_sec_v  = load ? ld_sec_c : rl_sec_q;
`else
  assign reload_hit = 1'b0;
  assign cnt_ld     = load;
  assign cnt_min_v  = ld_min_c;
  assign cnt_sec_v  = ld_sec_c;
`endif

  ct_down_mod_N #(.N(SEC_N)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .en     (run_tick),
    .ld     (cnt_ld),
    .ld_val (cnt_sec_v),
    .ct_out (sec_out),
    .z      (sec_z)
  );

  // Minutes only move on the borrow out of seconds.
  ct_down_mod_N #(.N(MIN_MAX + 1)) u_min (
    .clk    (clk),
    .rst    (rst),
    .en     (run_tick & sec_z),
    .ld     (cnt_ld),
    .ld_val (cnt_min_v),
    .ct_out (min_out),
    .z      (min_z)
  );

  assign startable = (state_q == IDLE) | (state_q == PAUSE);

  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      load: state_d = IDLE;
      stop: begin
        if (state_q == RUN) begin
          state_d = PAUSE;
        end else if (state_q == EXPIRED) begin
          state_d = IDLE;
        end
      end
      (start & startable): begin
        if (!cnt_zero) begin
          state_d = RUN;
        end
      end
      expiring: begin
        if (!reload_hit) begin
          state_d = EXPIRED;
        end
      end
      default: ;
    endcase
    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED) | reload_hit;
    buzz_d    = expiring;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      buzz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      expired_q <= expired_d;
      buzz_q    <= buzz_d;
    end
  end

  assign running = running_q;
  assign expired = expired_q;
  assign buzz    = buzz_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus
// random traffic against a seconds-total reference model.
module tb_countdown_timer;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_EXP   = 3;

  logic clk = 1'b0;
  logic rst, tick, load, start, stop;
  logic [6:0] ld_min, ld_sec;
  logic [6:0] min_out, sec_out;
  logic running, expired, buzz;

  int ncmp = 0;
  int nerr = 0;

  int   m_total;
  int   m_state;
  int   m_rl;
  logic m_buzz;
  logic m_pulse;

  countdown_timer dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .load    (load),
    .ld_min  (ld_min),
    .ld_sec  (ld_sec),
    .start   (start),
    .stop    (stop),
    .min_out (min_out),
    .sec_out (sec_out),
    .running (running),
    .expired (expired),
    .buzz    (buzz)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] obs();
    return {min_out, sec_out, running, expired, buzz};
  endfunction

  function automatic logic [16:0] mexp();
    logic r, e;
    r = (m_state == S_RUN);
    e = (m_state == S_EXP) || m_pulse;
    return {7'(m_total / 60), 7'(m_total % 60), r, e, m_buzz};
  endfunction

  function automatic logic [16:0] pk(
    input int mm, input int ss,
    input logic r, input logic e, input logic b
  );
    return {7'(mm), 7'(ss), r, e, b};
  endfunction

  // Drive one cycle of inputs and advance the reference model.
  task automatic step(
    input logic r, input logic ld,
    input int lm, input int ls,
    input logic st, input logic sp, input logic tk
  );
    int cm, cs;
    @(negedge clk);
    rst = r; load = ld; ld_min = 7'(lm); ld_sec = 7'(ls);
    start = st; stop = sp; tick = tk;
    @(posedge clk);
    m_buzz  = 1'b0;
    m_pulse = 1'b0;
    if (r) begin
      m_total = 0; m_state = S_IDLE; m_rl = 0;
    end else if (ld) begin
      cm = (lm > 59) ? 59 : lm;
      cs = (ls > 59) ? 59 : ls;
      m_rl = cm * 60 + cs;
      m_total = m_rl;
      m_state = S_IDLE;
    end else if (sp) begin
      if (m_state == S_RUN) m_state = S_PAUSE;
      else if (m_state == S_EXP) m_state = S_IDLE;
    end else if (st && (m_state == S_IDLE || m_state == S_PAUSE)) begin
      if (m_total != 0) m_state = S_RUN;
    end else if (tk && m_state == S_RUN) begin
      m_total = m_total - 1;
      if (m_total == 0) begin
        m_buzz = 1'b1;
`ifdef AUTO_RELOAD_EN
        if (m_rl != 0) begin
          m_total = m_rl;
          m_pulse = 1'b1;
        end else begin
          m_state = S_EXP;
        end
`else
        m_state = S_EXP;
`endif
      end
    end
    #1;
    rst = 0; load = 0; start = 0; stop = 0; tick = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 1, 5, 5, 1, 0, 1);
    ncmp++;
    if (obs() !== 17'd0) begin
      $display("FAIL reset_out: got %h want %h", obs(), 17'd0);
      nerr++;
    end
    step(0, 0, 0, 0, 1, 0, 1);
    ncmp++;
    if (obs() !== 17'd0) begin
      $display("FAIL reset_start_zero: got %h want %h", obs(), 17'd0);
      nerr++;
    end
  endtask

  task automatic test_basic();
    logic [16:0] e;
    step(0, 1, 0, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    ncmp++;
    if (obs() !== pk(0, 3, 1, 0, 0)) begin
      $display("FAIL basic_start: got %h want %h", obs(), pk(0, 3, 1, 0, 0));
      nerr++;
    end
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
`ifdef AUTO_RELOAD_EN
      e = (i < 3) ? pk(0, 3 - i, 1, 0, 0) : pk(0, 3, 1, 1, 1);
`else
      e = (i < 3) ? pk(0, 3 - i, 1, 0, 0) : pk(0, 0, 0, 1, 1);
`endif
      ncmp++;
      if (obs() !== e) begin
        $display("FAIL basic_tick%0d: got %h want %h", i, obs(), e);
        nerr++;
      end
      idle(1);
      ncmp++;
      if (buzz !== 1'b0) begin
        $display("FAIL basic_buzz_len%0d: got %b want 0", i, buzz);
        nerr++;
      end
      idle(8);
    end
    step(0, 0, 0, 0, 0, 0, 1);
`ifdef AUTO_RELOAD_EN
    e = pk(0, 2, 1, 0, 0);
`else
    e = pk(0, 0, 0, 1, 0);
`endif
    ncmp++;
    if (obs() !== e) begin
      $display("FAIL basic_tick4: got %h want %h", obs(), e);
      nerr++;
    end
  endtask

  task automatic test_borrow();
    step(0, 1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    ncmp++;
    if (obs() !== pk(1, 59, 1, 0, 0)) begin
      $display("FAIL borrow_1_59: got %h want %h", obs(), pk(1, 59, 1, 0, 0));
      nerr++;
    end
    for (int i = 0; i < 120; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      ncmp++;
      if (obs() !== mexp()) begin
        $display("FAIL borrow_run%0d: got %h want %h", i, obs(), mexp());
        nerr++;
      end
      if (i == 118) begin
        ncmp++;
`ifdef AUTO_RELOAD_EN
        if (obs() !== pk(2, 0, 1, 1, 1)) begin
          $display("FAIL borrow_end: got %h want %h", obs(), pk(2, 0, 1, 1, 1));
          nerr++;
        end
`else
        if (obs() !== pk(0, 0, 0, 1, 1)) begin
          $display("FAIL borrow_end: got %h want %h", obs(), pk(0, 0, 0, 1, 1));
          nerr++;
        end
`endif
      end
    end
  endtask

  task automatic test_pause();
    step(0, 1, 0, 10, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      ncmp++;
      if (obs() !== pk(0, 10, 0, 0, 0)) begin
        $display("FAIL pause_hold%0d: got %h want %h", i, obs(), pk(0, 10, 0, 0, 0));
        nerr++;
      end
    end
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    ncmp++;
    if (obs() !== pk(0, 9, 1, 0, 0)) begin
      $display("FAIL pause_resume: got %h want %h", obs(), pk(0, 9, 1, 0, 0));
      nerr++;
    end
  endtask

  task automatic test_clamp();
    step(0, 1, 90, 75, 0, 0, 0);
    ncmp++;
    if (obs() !== pk(59, 59, 0, 0, 0)) begin
      $display("FAIL clamp_90_75: got %h want %h", obs(), pk(59, 59, 0, 0, 0));
      nerr++;
    end
    step(0, 1, 60, 60, 0, 0, 0);
    ncmp++;
    if (obs() !== pk(59, 59, 0, 0, 0)) begin
      $display("FAIL clamp_60_60: got %h want %h", obs(), pk(59, 59, 0, 0, 0));
      nerr++;
    end
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    ncmp++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      $display("FAIL start_at_zero: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
      nerr++;
    end
  endtask

  task automatic test_simul();
    step(0, 1, 0, 5, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    ncmp++;
    if (obs() !== pk(0, 5, 0, 0, 0)) begin
      $display("FAIL start_stop_pause: got %h want %h", obs(), pk(0, 5, 0, 0, 0));
      nerr++;
    end
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 7, 1, 0, 1);
    ncmp++;
    if (obs() !== pk(1, 7, 0, 0, 0)) begin
      $display("FAIL load_tick_run: got %h want %h", obs(), pk(1, 7, 0, 0, 0));
      nerr++;
    end
    step(0, 1, 3, 21, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    ncmp++;
    if (obs() !== pk(3, 21, 1, 0, 0)) begin
      $display("FAIL run_3_21: got %h want %h", obs(), pk(3, 21, 1, 0, 0));
      nerr++;
    end
    step(1, 1, 9, 9, 1, 0, 1);
    ncmp++;
    if (obs() !== 17'd0) begin
      $display("FAIL rst_mid_run: got %h want %h", obs(), 17'd0);
      nerr++;
    end
  endtask

  task automatic test_mode();
    step(0, 1, 0, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
`ifdef AUTO_RELOAD_EN
    ncmp++;
    if (obs() !== pk(0, 2, 1, 1, 1)) begin
      $display("FAIL mode_reload: got %h want %h", obs(), pk(0, 2, 1, 1, 1));
      nerr++;
    end
    idle(1);
    ncmp++;
    if (obs() !== pk(0, 2, 1, 0, 0)) begin
      $display("FAIL mode_after: got %h want %h", obs(), pk(0, 2, 1, 0, 0));
      nerr++;
    end
`else
    ncmp++;
    if (obs() !== pk(0, 0, 0, 1, 1)) begin
      $display("FAIL mode_expire: got %h want %h", obs(), pk(0, 0, 0, 1, 1));
      nerr++;
    end
    idle(3);
    ncmp++;
    if (obs() !== pk(0, 0, 0, 1, 0)) begin
      $display("FAIL mode_hold: got %h want %h", obs(), pk(0, 0, 0, 1, 0));
      nerr++;
    end
    step(0, 0, 0, 0, 0, 1, 0);
    ncmp++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      $display("FAIL mode_ack: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
      nerr++;
    end
`endif
  endtask

  task automatic test_random();
    logic r, ld, st, sp, tk;
    int lm, ls;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(199) == 0);
      ld = ($urandom_range(39) == 0);
      lm = ($urandom_range(7) == 0) ? int'($urandom_range(127)) : int'($urandom_range(2));
      ls = ($urandom_range(7) == 0) ? int'($urandom_range(127)) : int'($urandom_range(5));
      st = ($urandom_range(5) == 0);
      sp = ($urandom_range(19) == 0);
      tk = ($urandom_range(2) == 0);
      step(r, ld, lm, ls, st, sp, tk);
      ncmp++;
      if (obs() !== mexp()) begin
        $display("FAIL random_%0d: got %h want %h", i, obs(), mexp());
        nerr++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    ld_min = '0; ld_sec = '0;
    m_total = 0; m_state = S_IDLE; m_rl = 0;
    m_buzz = 1'b0; m_pulse = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_pause();
    test_clamp();
    test_simul();
    test_mode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
